// File: rtl/prio_scan_encoder.sv
// rtl/prio_scan_encoder.sv - captures a request vector and streams its set-bit indices in priority order (optional PENC_ONEHOT_EN)
module prio_scan_encoder #(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         in_req,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(WIDTH)-1:0] out_idx,
    output logic                     out_last,
    output logic                     out_none
`ifdef PENC_ONEHOT_EN
    ,
    output logic [WIDTH-1:0]         out_onehot
`endif
);

    localparam int IDX_W = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    typedef enum logic {
        S_IDLE,
        S_SCAN
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] pending;
    logic [WIDTH-1:0] pending_nxt;
    logic             zero_flag;
    logic             zero_nxt;
    logic [IDX_W-1:0] cur_idx;
    logic             cur_last;

    // Later matches overwrite earlier ones, so scan order decides which end wins.
    function automatic logic [IDX_W-1:0] prio_idx(input logic [WIDTH-1:0] v);
        logic [IDX_W-1:0] r;
        r = '0;
        if (MSB_FIRST != 0) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (v[i]) r = IDX_W'(i);
            end
        end else begin
            for (int i = WIDTH - 1; i >= 0; i--) begin
                if (v[i]) r = IDX_W'(i);
            end
        end
        return r;
    endfunction

    assign cur_idx  = prio_idx(pending);
    assign cur_last = ((pending & (pending - ONE)) == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            pending   <= '0;
            zero_flag <= 1'b0;
        end else begin
            state     <= state_nxt;
            pending   <= pending_nxt;
            zero_flag <= zero_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        pending_nxt = pending;
        zero_nxt    = zero_flag;
        case (state)
            S_IDLE: begin
                if (in_valid) begin
                    pending_nxt = in_req;
                    zero_nxt    = (in_req == '0);
                    state_nxt   = S_SCAN;
                end
            end
            S_SCAN: begin
                if (out_ready) begin
                    pending_nxt = pending & ~(ONE << cur_idx);
                    if (cur_last) begin
                        zero_nxt  = 1'b0;
                        state_nxt = S_IDLE;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // All outputs are functions of registered state only; IDLE forces them to their rest values.
    always_comb begin
        in_ready  = (state == S_IDLE);
        out_valid = (state == S_SCAN);
        out_idx   = out_valid ? cur_idx : '0;
        out_last  = out_valid && cur_last;
        out_none  = out_valid && zero_flag;
    end

`ifdef PENC_ONEHOT_EN
    assign out_onehot = (out_valid && !zero_flag) ? (ONE << cur_idx) : '0;
`endif

endmodule
